frv_masked_shfrot_sched: RTL and testbench

Scheduler that shares one masked shift/rotate unit (2-share Boolean masking, `srli`/`slli`/`rori`) between `N_REQ` requesters. It sits between the masked-instruction issue ports and the shfrot datapath. Its jobs:
- round-robin arbitration;
- operand capture;
- sequencing the unit's `ena`/`ready` handshake;
- supplying fresh padding randomness;
- zeroing the unit's share inputs between operations, so no two unrelated operations' shares are ever adjacent on the datapath;
- a timeout on a stalled unit.

---
 rtl/frv_masked_shfrot_pkg.sv | 20 ++
 rtl/frv_rr_arbiter.sv | 32 +++
 rtl/frv_masked_shfrot_sched.sv | 223 ++++++++++++++++++++++
 tb/tb_frv_masked_shfrot_sched.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frv_masked_shfrot_pkg.sv
// Shared types and constants for the masked shift/rotate scheduler.
package frv_masked_shfrot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  localparam int OP_SRLI = 0;
  localparam int OP_SLLI = 1;
  localparam int OP_RORI = 2;
  localparam int SHAMT_W = 5;

  // An opcode is legal only when exactly one of {rori, slli, srli} is set.
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b010) || (op == 3'b100);
  endfunction

endpackage

// File: rtl/frv_rr_arbiter.sv
// Combinational N-way round-robin arbiter: searches upward from last_grant+1.
module frv_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic found;

  // Pick the first requester at distance 1..N_REQ from the previous winner.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && req_i[i] && (((int'(last_grant_i) + k) % N_REQ) == i)) begin
          found     = 1'b1;
          gnt_o[i]  = 1'b1;
          gnt_idx_o = IDX_W'(i);
        end else begin
          found = found;
        end
      end
    end
  end

endmodule

// File: rtl/frv_masked_shfrot_sched.sv
// Shares one masked shift/rotate unit between N_REQ requesters, keeping the
// unit's inputs zero outside an operation and never recombining shares.
module frv_masked_shfrot_sched
  import frv_masked_shfrot_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int N_REQ     = 2,
  parameter int TIMEOUT   = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [3*N_REQ-1:0]         req_op,
  input  logic [5*N_REQ-1:0]         req_shamt,
  input  logic [BIT_WIDTH*N_REQ-1:0] req_s0,
  input  logic [BIT_WIDTH*N_REQ-1:0] req_s1,
  output logic                       rsp_valid,
  output logic [1:0]                 rsp_id,
  output logic                       rsp_err,
  output logic [BIT_WIDTH-1:0]       rsp_r0,
  output logic [BIT_WIDTH-1:0]       rsp_r1,
  input  logic                       rsp_ready,
  input  logic                       rng_valid,
  input  logic [BIT_WIDTH-1:0]       rng_data,
  output logic                       rng_take,
  output logic                       su_ena,
  output logic                       su_srli,
  output logic                       su_slli,
  output logic                       su_rori,
  output logic [5:0]                 su_shamt,
  output logic [BIT_WIDTH-1:0]       su_s0,
  output logic [BIT_WIDTH-1:0]       su_s1,
  output logic [BIT_WIDTH-1:0]       su_rp0,
  input  logic [BIT_WIDTH-1:0]       su_r0,
  input  logic [BIT_WIDTH-1:0]       su_r1,
  input  logic                       su_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  sched_state_t           state_q, state_d;
  logic [1:0]             last_grant_q, last_grant_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   su_ena_q, su_ena_d;
  logic [2:0]             su_op_q, su_op_d;
  logic [SHAMT_W-1:0]     su_shamt_q, su_shamt_d;
  logic [BIT_WIDTH-1:0]   su_s0_q, su_s0_d, su_s1_q, su_s1_d, su_rp0_q, su_rp0_d;
  logic                   rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [1:0]             rsp_id_q, rsp_id_d;
  logic [BIT_WIDTH-1:0]   rsp_r0_q, rsp_r0_d, rsp_r1_q, rsp_r1_d;

  logic [N_REQ-1:0]       gnt_s;
  logic [1:0]             gnt_idx_s;
  logic                   accept_s;
  logic [2:0]             sel_op_s;
  logic [SHAMT_W-1:0]     sel_shamt_s;
  logic [BIT_WIDTH-1:0]   sel_s0_s, sel_s1_s;

  frv_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(2)) u_arb (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt_s),
    .gnt_idx_o    (gnt_idx_s)
  );

  // Grant is offered only in IDLE and only when fresh padding randomness exists.
  always_comb begin
    req_ready = '0;
    if ((state_q == IDLE) && rng_valid) begin
      req_ready = gnt_s;
    end else begin
      req_ready = '0;
    end
    accept_s = |req_ready;
    rng_take = accept_s;
  end

  // Route the granted requester's operands onto a single capture path.
  always_comb begin
    sel_op_s    = '0;
    sel_shamt_s = '0;
    sel_s0_s    = '0;
    sel_s1_s    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_s[i]) begin
        sel_op_s    = req_op[3*i +: 3];
        sel_shamt_s = req_shamt[SHAMT_W*i +: SHAMT_W];
        sel_s0_s    = req_s0[BIT_WIDTH*i +: BIT_WIDTH];
        sel_s1_s    = req_s1[BIT_WIDTH*i +: BIT_WIDTH];
      end else begin
        sel_op_s = sel_op_s;
      end
    end
  end

  // Next-state logic: IDLE accepts, BUSY drives the unit, RESP holds the answer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    su_ena_d     = su_ena_q;
    su_op_d      = su_op_q;
    su_shamt_d   = su_shamt_q;
    su_s0_d      = su_s0_q;
    su_s1_d      = su_s1_q;
    su_rp0_d     = su_rp0_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    rsp_r0_d     = rsp_r0_q;
    rsp_r1_d     = rsp_r1_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          last_grant_d = gnt_idx_s;
          rsp_id_d     = gnt_idx_s;
          if (op_is_legal(sel_op_s)) begin
            state_d    = BUSY;
            cnt_d      = '0;
            su_ena_d   = 1'b1;
            su_op_d    = sel_op_s;
            su_shamt_d = sel_shamt_s;
            su_s0_d    = sel_s0_s;
            su_s1_d    = sel_s1_s;
            su_rp0_d   = rng_data;
          end else begin
            // Illegal opcode: answer with an error and keep the unit inputs at zero.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_r0_d    = '0;
            rsp_r1_d    = '0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (su_ready || (cnt_q == CNT_W'(TIMEOUT))) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = !su_ready;
          rsp_r0_d    = su_ready ? su_r0 : '0;
          rsp_r1_d    = su_ready ? su_r1 : '0;
          su_ena_d    = 1'b0;
          su_op_d     = '0;
          su_shamt_d  = '0;
          su_s0_d     = '0;
          su_s1_d     = '0;
          su_rp0_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_id_d    = 2'd0;
          rsp_r0_d    = '0;
          rsp_r1_d    = '0;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 2'(N_REQ - 1);
      cnt_q        <= '0;
      su_ena_q     <= 1'b0;
      su_op_q      <= '0;
      su_shamt_q   <= '0;
      su_s0_q      <= '0;
      su_s1_q      <= '0;
      su_rp0_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 2'd0;
      rsp_err_q    <= 1'b0;
      rsp_r0_q     <= '0;
      rsp_r1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      su_ena_q     <= su_ena_d;
      su_op_q      <= su_op_d;
      su_shamt_q   <= su_shamt_d;
      su_s0_q      <= su_s0_d;
      su_s1_q      <= su_s1_d;
      su_rp0_q     <= su_rp0_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      rsp_r0_q     <= rsp_r0_d;
      rsp_r1_q     <= rsp_r1_d;
    end
  end

  assign su_ena    = su_ena_q;
  assign su_srli   = su_op_q[OP_SRLI];
  assign su_slli   = su_op_q[OP_SLLI];
  assign su_rori   = su_op_q[OP_RORI];
  assign su_shamt  = {1'b0, su_shamt_q};
  assign su_s0     = su_s0_q;
  assign su_s1     = su_s1_q;
  assign su_rp0    = su_rp0_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_r0    = rsp_r0_q;
  assign rsp_r1    = rsp_r1_q;

endmodule

// File: tb/tb_frv_masked_shfrot_sched.sv
// Randomized self-checking bench for frv_masked_shfrot_sched with a
// behavioural masked-unit model and an arithmetic reference for results.
module tb_frv_masked_shfrot_sched;

  localparam int BW = 32;
  localparam int NR = 2;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid, req_ready;
  logic [3*NR-1:0] req_op;
  logic [5*NR-1:0] req_shamt;
  logic [BW*NR-1:0] req_s0, req_s1;
  logic            rsp_valid, rsp_err, rsp_ready;
  logic [1:0]      rsp_id;
  logic [BW-1:0]   rsp_r0, rsp_r1;
  logic            rng_valid, rng_take;
  logic [BW-1:0]   rng_data;
  logic            su_ena, su_srli, su_slli, su_rori, su_ready;
  logic [5:0]      su_shamt;
  logic [BW-1:0]   su_s0, su_s1, su_rp0, su_r0, su_r1;

  // Per-requester operands held by the bench.
  logic [2:0]    op_a [NR];
  logic [4:0]    sh_a [NR];
  logic [BW-1:0] s0_a [NR];
  logic [BW-1:0] s1_a [NR];

  int n_chk = 0;
  int n_err = 0;
  int um_cnt = 0;
  int um_lat = 1;
  bit um_stall = 1'b0;
  int exp_last = NR - 1;

  always #5 clk = ~clk;

  frv_masked_shfrot_sched #(.BIT_WIDTH(BW), .N_REQ(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_shamt(req_shamt), .req_s0(req_s0), .req_s1(req_s1),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .rsp_r0(rsp_r0), .rsp_r1(rsp_r1), .rsp_ready(rsp_ready),
    .rng_valid(rng_valid), .rng_data(rng_data), .rng_take(rng_take),
    .su_ena(su_ena), .su_srli(su_srli), .su_slli(su_slli), .su_rori(su_rori),
    .su_shamt(su_shamt), .su_s0(su_s0), .su_s1(su_s1), .su_rp0(su_rp0),
    .su_r0(su_r0), .su_r1(su_r1), .su_ready(su_ready)
  );

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference shift/rotate on an unmasked 32-bit value; op is {rori, slli, srli}.
  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] x, input int sh);
    logic [63:0] d;
    d = {x, x} >> sh;
    case (op)
      3'b001:  return x >> sh;
      3'b010:  return x << sh;
      3'b100:  return d[31:0];
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive_reqs();
    req_op    = {op_a[1], op_a[0]};
    req_shamt = {sh_a[1], sh_a[0]};
    req_s0    = {s0_a[1], s0_a[0]};
    req_s1    = {s1_a[1], s1_a[0]};
  endtask

  task automatic rand_req(input int id);
    op_a[id] = 3'b001 << $urandom_range(0, 2);
    sh_a[id] = 5'($urandom_range(0, 31));
    s0_a[id] = $urandom;
    s1_a[id] = $urandom;
  endtask

  // One clock: sample after the edge, check hygiene, then update the unit model.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (!su_ena)
      chk("hygiene", (|su_s0) | (|su_s1) | (|su_rp0) | (|su_shamt) | su_srli | su_slli | su_rori, 1'b0);
    if (rsp_valid)
      chk("ena_in_resp", su_ena, 1'b0);
    if (su_ena) begin
      um_cnt++;
      if (!um_stall && um_cnt >= um_lat) begin
        su_ready = 1'b1;
        su_r0 = ref_op({su_rori, su_slli, su_srli}, su_s0, int'(su_shamt)) ^ su_rp0;
        su_r1 = ref_op({su_rori, su_slli, su_srli}, su_s1, int'(su_shamt)) ^ su_rp0;
      end else begin
        su_ready = 1'b0;
      end
    end else begin
      um_cnt   = 0;
      su_ready = 1'($urandom_range(0, 1));
      su_r0    = $urandom;
      su_r1    = $urandom;
    end
    rng_data = $urandom;
  endtask

  // mode 0: legal op, 1: illegal opcode, 2: unit stalls until timeout.
  task automatic run_txn(input int id, input int mode, input int lat, input int bp, input bit keep);
    logic [BW-1:0] rng_s, exp_r;
    logic [67:0] held;
    int k, busy;
    um_lat = lat;
    um_stall = (mode == 2);
    #1;
    k = 0;
    while (req_ready == '0 && k < 20) begin
      cyc();
      #1;
      k++;
    end
    chk("grant", req_ready, 2'b01 << id);
    chk("rng_take", rng_take, 1'b1);
    rng_s = rng_data;
    exp_r = (mode == 0) ? ref_op(op_a[id], s0_a[id] ^ s1_a[id], int'(sh_a[id])) : 32'h0;
    cyc();
    exp_last = id;
    if (!keep) req_valid[id] = 1'b0;
    if (mode != 1) begin
      chk("su_ena", su_ena, 1'b1);
      chk("su_s0", su_s0, s0_a[id]);
      chk("su_s1", su_s1, s1_a[id]);
      chk("su_rp0", su_rp0, rng_s);
      chk("su_shamt", su_shamt, {1'b0, sh_a[id]});
      chk("su_op", {su_rori, su_slli, su_srli}, op_a[id]);
    end else begin
      chk("illegal_resp", {rsp_valid, su_ena}, 2'b10);
    end
    busy = 0;
    k = 0;
    while (!rsp_valid && k < 40) begin
      if (su_ena) busy++;
      cyc();
      k++;
    end
    chk("rsp_valid", rsp_valid, 1'b1);
    if (mode == 2) chk("timeout_cycles", busy, TO + 1);
    chk("rsp_id", rsp_id, id);
    chk("rsp_err", rsp_err, mode != 0);
    chk("rsp_result", rsp_r0 ^ rsp_r1, exp_r);
    if (mode != 0) chk("rsp_zero", {rsp_r0, rsp_r1}, 64'h0);
    held = {rsp_valid, rsp_id, rsp_err, rsp_r0, rsp_r1};
    for (int j = 0; j < bp; j++) begin
      cyc();
      chk("bp_stable", {rsp_valid, rsp_id, rsp_err, rsp_r0, rsp_r1}, held);
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 1'b0);
  endtask

  initial begin
    int k, id, mode;
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; rng_valid = 1'b0; rng_data = '0;
    su_ready = 1'b0; su_r0 = '0; su_r1 = '0;
    for (int i = 0; i < NR; i++) rand_req(i);
    drive_reqs();
    cyc(); cyc();
    chk("rst_outputs", {req_ready, rsp_valid, su_ena, rsp_id, rsp_err, rsp_r0, rsp_r1, rng_take}, 96'h0);
    rst = 1'b0;
    cyc();

    // Fixed vectors from requester 1.
    rng_valid = 1'b1;
    s0_a[1] = 32'h0484D609; s1_a[1] = 32'h31F05663; sh_a[1] = 5'd4;
    op_a[1] = 3'b010; drive_reqs(); req_valid = 2'b10;
    chk("vec_slli", ref_op(op_a[1], s0_a[1] ^ s1_a[1], 4), 32'h574806A0);
    run_txn(1, 0, 3, 5, 1'b0);
    op_a[1] = 3'b100; drive_reqs(); req_valid = 2'b10;
    run_txn(1, 0, 1, 0, 1'b0);
    op_a[1] = 3'b001; drive_reqs(); req_valid = 2'b10;
    run_txn(1, 0, 2, 1, 1'b0);

    // Randomness starvation then release.
    rng_valid = 1'b0; rand_req(0); drive_reqs(); req_valid = 2'b01;
    for (int j = 0; j < 4; j++) begin
      cyc();
      chk("starve", {req_ready, rng_take, su_ena}, 4'h0);
    end
    rng_valid = 1'b1;
    run_txn(0, 0, 2, 0, 1'b0);

    // Illegal opcode and unit timeout.
    op_a[0] = 3'b011; drive_reqs(); req_valid = 2'b01;
    run_txn(0, 1, 1, 2, 1'b0);
    rand_req(1); drive_reqs(); req_valid = 2'b10;
    run_txn(1, 2, 1, 0, 1'b0);

    // Fairness with both requesters continuously valid.
    req_valid = 2'b11;
    for (int t = 0; t < 6; t++) begin
      rand_req(0); rand_req(1); drive_reqs();
      run_txn((exp_last + 1) % NR, 0, int'($urandom_range(1, 3)), 0, 1'b1);
    end
    req_valid = '0;

    // Reset in the middle of a stalled operation.
    rand_req(0); drive_reqs(); req_valid = 2'b01;
    run_txn(0, 0, 1, 0, 1'b0);
    rand_req(1); drive_reqs(); req_valid = 2'b10;
    um_stall = 1'b1;
    #1;
    k = 0;
    while (req_ready == '0 && k < 20) begin cyc(); #1; k++; end
    chk("rst_pre_grant", req_ready, 2'b10);
    cyc();
    req_valid = '0;
    cyc(); cyc(); cyc();
    chk("busy_before_rst", su_ena, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("after_rst", {su_ena, rsp_valid, su_s0, su_rp0}, 66'h0);
    exp_last = NR - 1;
    rand_req(0); rand_req(1); drive_reqs(); req_valid = 2'b11;
    run_txn(0, 0, 2, 0, 1'b0);
    req_valid = '0;

    // Random traffic.
    for (int t = 0; t < 12; t++) begin
      id = int'($urandom_range(0, NR - 1));
      rand_req(id);
      mode = ($urandom_range(0, 7) == 0) ? 1 : 0;
      if (mode == 1) op_a[id] = 3'b110;
      drive_reqs();
      req_valid = '0;
      req_valid[id] = 1'b1;
      run_txn(id, mode, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
